// File: rtl/video_fifo_axi_wr_burst_if.sv
// AXI4 write-channel bundle (AW/W/B) for the video FIFO drain stage.
// master: burst generator side; slave: interconnect / memory side.
interface video_fifo_axi_wr_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [3:0]              awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/video_fifo_axi_wr_burst.sv
// Drains the video write FIFO in fixed-length AXI4 INCR write bursts,
// walking a linear address through one frame region (wraps, re-based by
// frame_start). Ports: rd_clk/rd_rst, frame_start, FIFO read side
// (fifo_rd_*), AXI write bus m (AW/W/B), busy, err.
// Optional: define VIDEO_AXI_WR_ERR_EN for a sticky bad-bresp flag on err.
module video_fifo_axi_wr_burst #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          LEVEL_WIDTH = 11,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          BURST_LEN   = 16,
    parameter int unsigned FRAME_BASE  = 0,
    parameter int unsigned FRAME_BYTES = 3686400,
    parameter logic [3:0]  AXI_ID      = 4'd0
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   frame_start,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    video_fifo_axi_wr_burst_if.master m,
    output logic                   busy,
    output logic                   err
);
    localparam int BB = BURST_LEN * DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [ADDR_WIDTH-1:0] LIMIT =
        ADDR_WIDTH'(FRAME_BASE + FRAME_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
    logic                  pend_q, pend_d;
    logic [8:0]            rcnt_q, rcnt_d;
    logic [8:0]            bcnt_q, bcnt_d;
    logic                  infl_q;
    logic [DATA_WIDTH-1:0] sk_q [2];
    logic                  sk_wp_q, sk_rp_q;
    logic [1:0]            sk_n_q;
    logic [1:0]            occ;
    logic                  pop, last;

    assign m.awid    = AXI_ID;
    assign m.awaddr  = addr_q;
    assign m.awlen   = 8'(BURST_LEN - 1);
    assign m.awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m.awburst = 2'b01;
    assign m.awvalid = (state_q == S_AW);
    assign m.wvalid  = (state_q == S_W) && (sk_n_q != 2'd0);
    assign m.wdata   = sk_q[sk_rp_q];
    assign m.wstrb   = '1;
    assign last      = (bcnt_q == 9'(BURST_LEN - 1));
    assign m.wlast   = m.wvalid && last;
    assign m.bready  = (state_q == S_B);
    assign busy      = (state_q != S_IDLE);

    assign pop = m.wvalid && m.wready;
    // Occupancy after this cycle's pop, so a read can be issued every
    // cycle while the consumer keeps pace.
    assign occ = sk_n_q - 2'(pop);
    assign fifo_rd_en = (state_q == S_W) &&
                        (rcnt_q < 9'(BURST_LEN)) &&
                        (3'(occ) + 3'(infl_q) < 3'd2) &&
                        !fifo_rd_empty;

    assign addr_nxt = addr_q + ADDR_WIDTH'(BB);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q | frame_start;
        rcnt_d  = rcnt_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    addr_d = BASE;
                    pend_d = frame_start;
                end
                if (fifo_rd_water_level >= LEVEL_WIDTH'(BURST_LEN))
                    state_d = S_AW;
            end
            S_AW: begin
                if (m.awready) begin
                    state_d = S_W;
                    rcnt_d  = '0;
                    bcnt_d  = '0;
                end
            end
            S_W: begin
                if (fifo_rd_en)
                    rcnt_d = rcnt_q + 9'd1;
                if (pop) begin
                    bcnt_d = bcnt_q + 9'd1;
                    if (last)
                        state_d = S_B;
                end
            end
            default: begin
                if (m.bvalid) begin
                    addr_d  = (addr_nxt == LIMIT) ? BASE : addr_nxt;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            pend_q  <= 1'b0;
            rcnt_q  <= '0;
            bcnt_q  <= '0;
            infl_q  <= 1'b0;
            sk_wp_q <= 1'b0;
            sk_rp_q <= 1'b0;
            sk_n_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            rcnt_q  <= rcnt_d;
            bcnt_q  <= bcnt_d;
            infl_q  <= fifo_rd_en;
            if (infl_q)
                sk_wp_q <= ~sk_wp_q;
            if (pop)
                sk_rp_q <= ~sk_rp_q;
            sk_n_q <= sk_n_q + 2'(infl_q) - 2'(pop);
        end
    end

    // Skid payload needs no reset; occupancy gates its use.
    always_ff @(posedge rd_clk) begin
        if (infl_q)
            sk_q[sk_wp_q] <= fifo_rd_data;
    end

`ifdef VIDEO_AXI_WR_ERR_EN
    logic err_q;
    always_ff @(posedge rd_clk) begin
        if (rd_rst)
            err_q <= 1'b0;
        else if ((state_q == S_B) && m.bvalid && (m.bresp != 2'b00))
            err_q <= 1'b1;
    end
    assign err = err_q;
`else
    wire unused_bresp = ^m.bresp;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_video_fifo_axi_wr_burst.sv
// Randomized scoreboard bench for video_fifo_axi_wr_burst.
// Queue-based FIFO model feeds the DUT; a negedge monitor checks AXI output.
module tb_video_fifo_axi_wr_burst;
    localparam int DW = 32;
    localparam int BL = 16;
    localparam int FB = 128;
    localparam int BB = BL * DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic [10:0]   lvl = '0;
    logic          busy, err;

    video_fifo_axi_wr_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(32)) axi();

    video_fifo_axi_wr_burst #(
        .DATA_WIDTH(DW), .LEVEL_WIDTH(11), .ADDR_WIDTH(32),
        .BURST_LEN(BL), .FRAME_BASE(0), .FRAME_BYTES(FB), .AXI_ID(4'd0)
    ) dut (
        .rd_clk(clk), .rd_rst(rst), .frame_start(frame_start),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(lvl),
        .m(axi), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO model and scoreboard queues
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int pushed = 0;
    int rd_total = 0;
    int rd_burst = 0;

    task automatic push_words(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            fq.push_back(w);
            exp_q.push_back(w);
            pushed++;
        end
    endtask

    always @(posedge clk) begin
        if (!rst && fifo_rd_en) begin
            rd_total++;
            rd_burst++;
            if (fq.size() == 0) begin
                failures++;
                $display("FAIL fifo_underflow: read from empty FIFO");
            end else begin
                fifo_rd_data <= fq.pop_front();
            end
        end
        lvl <= 11'(fq.size());
        fifo_rd_empty <= (fq.size() == 0);
    end

    // Slave driver
    bit aw_rand = 0, w_rand = 0, b_rand = 0;
    bit fs_w_arm = 0, fs_b_arm = 0;
    int bad_idx = 1;
    int b_owed = 0;
    int b_done = 0;
    int w_beat = 0;

    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
    end

    always @(posedge clk) begin
        #1;
        frame_start = 1'b0;
        if (rst) begin
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            axi.bvalid  = 1'b0;
            axi.bresp   = 2'b00;
        end else begin
            axi.awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.bvalid  = (b_owed > 0) &&
                          (b_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            axi.bresp   = (axi.bvalid && b_done == bad_idx) ? 2'b10 : 2'b00;
            if (fs_b_arm && axi.bvalid && axi.bready) begin
                frame_start = 1'b1;
                fs_b_arm = 0;
            end
            if (fs_w_arm && axi.wvalid && w_beat >= 8) begin
                frame_start = 1'b1;
                fs_w_arm = 0;
            end
        end
    end

    // Monitor with spec-level reference model
    bit go = 0;
    bit fast = 0;
    logic [31:0] m_addr = 0;
    bit m_pend = 0;
    bit m_err = 0;
    int aw_out = 0;
    int cyc = 0, first_cyc = 0;
    bit aw_hold = 0, w_hold = 0;
    logic [31:0] aw_prev;
    logic [DW:0] w_prev;
    logic [DW-1:0] e;

    always @(negedge clk) begin
        if (go && !rst) begin
            cyc++;
            chk("err_flag", {63'd0, err}, {63'd0, m_err});
            if (aw_hold)
                chk("aw_stable", {axi.awvalid, axi.awaddr},
                    {1'b1, aw_prev});
            if (w_hold)
                chk("w_stable", {axi.wvalid, axi.wlast, axi.wdata},
                    {1'b1, w_prev});
            aw_hold = axi.awvalid && !axi.awready;
            aw_prev = axi.awaddr;
            w_hold  = axi.wvalid && !axi.wready;
            w_prev  = {axi.wlast, axi.wdata};
            if (axi.wvalid && aw_out == 0)
                chk("w_before_aw", 64'd1, 64'd0);
            if (axi.awvalid && axi.awready) begin
                chk("awaddr", axi.awaddr, m_addr);
                chk("aw_fields",
                    {axi.awid, axi.awlen, axi.awsize, axi.awburst},
                    {4'd0, 8'd15, 3'd2, 2'd1});
                aw_out++;
                rd_burst = 0;
            end
            if (axi.wvalid && axi.wready) begin
                if (exp_q.size() == 0) begin
                    chk("wdata_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wdata", axi.wdata, e);
                end
                chk("wstrb", axi.wstrb, 4'hF);
                chk("wlast", axi.wlast, w_beat == BL - 1);
                if (w_beat == 0)
                    first_cyc = cyc;
                if (w_beat == BL - 1) begin
                    chk("rd_en_per_burst", rd_burst, BL);
                    if (fast)
                        chk("beat_gap", cyc - first_cyc, BL - 1);
                    b_owed++;
                    aw_out--;
                    w_beat = 0;
                end else begin
                    w_beat++;
                end
            end
            if (frame_start)
                m_pend = 1;
            if (axi.bvalid && axi.bready) begin
`ifdef VIDEO_AXI_WR_ERR_EN
                if (axi.bresp != 2'b00)
                    m_err = 1;
`endif
                m_addr = (m_addr + BB) % FB;
                if (m_pend)
                    m_addr = 0;
                m_pend = 0;
                b_owed--;
                b_done++;
            end
        end
    end

    task automatic wait_b(input int n);
        int t = 0;
        while (b_done < n && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("burst_done_timeout", b_done >= n, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_busy_err", {busy, err}, 2'b00);
        rst = 1'b0;
        go = 1;

        // below threshold: no burst
        push_words(BL - 1);
        repeat (10) @(negedge clk);
        chk("no_aw_at_15", {axi.awvalid, busy}, 2'b00);
        push_words(1);
        @(negedge clk);
        chk("aw_not_yet", axi.awvalid, 0);
        @(negedge clk);
        chk("aw_rises", axi.awvalid, 1);
        fast = 1;
        wait_b(1);

        // back-to-back full-speed bursts, wrap, bad response on burst 1
        push_words(2 * BL);
        wait_b(3);
        fast = 0;

        // random back-pressure with frame_start mid-W and on B handshake
        aw_rand = 1;
        w_rand  = 1;
        b_rand  = 1;
        push_words(5 * BL);
        fs_w_arm = 1;
        wait_b(5);
        fs_b_arm = 1;
        wait_b(8);
        repeat (20) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("rd_total", rd_total, pushed);
        chk("idle_at_end", busy, 0);

        // reset clears sticky error
        go = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_err_clear", {busy, err}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
